dm_result_checker: RTL and testbench
====================================

// Module: dm_result_checker
// PURPOSE
//   Synthesizable end-of-test checker for the 5-stage RISC-V core. Snoops the DM write port for the
//   end-of-simulation marker, then sweeps a DM result window against a golden ROM. Reports pass/fail,
//   error count and first failing index, so FPGA/emulation runs self-check without a host.
//   Sits beside i_DM in top: snoop port in parallel with CPU writes, read port on a spare DM port.
// PARAMETERS
//   AW          14              word-address width of DM/golden ROM
//   DW          32              data word width (DW/8 byte enables)
//   END_ADDR    14'h3fff        word address watched for the end marker
//   END_CODE    32'hffff_ffff   full-word value that signals end of test
//   TEST_START  14'h2000        first DM word of the result window
//   MAX_WORDS   1024            maximum words compared; sizes idx/err counters
//   MAX_CYCLES  100000          watchdog limit in clk cycles after reset release
//   STOP_ON_ERR 0               1: end sweep at first mismatch; 0: compare whole window
// PORTS
//   clk         in   1      clock, rising edge
//   rst         in   1      synchronous active-high reset
//   dm_we       in   DW/8   DM byte write enables, snooped (1 = byte written)
//   dm_addr     in   AW     DM word address, snooped
//   dm_wdata    in   DW     DM write data, snooped
//   chk_len     in   AW+1   golden word count, sampled on entry to SWEEP, clamped to MAX_WORDS
//   chk_addr    out  AW     DM read address = TEST_START + idx
//   chk_rdata   in   DW     DM read data, valid 1 cycle after chk_addr
//   gold_addr   out  AW     golden ROM address = idx
//   gold_rdata  in   DW     golden data, valid 1 cycle after gold_addr
//   busy        out  1      sweep in progress
//   done        out  1      check finished; held until rst
//   pass        out  1      done && err_cnt==0 && !timeout
//   timeout     out  1      watchdog expired before end marker
//   err_cnt     out  clog2(MAX_WORDS)+1  mismatch count
//   first_err   out  clog2(MAX_WORDS)    index of first mismatch (0 if none)
// BEHAVIOUR
//   - Reset: state=RUN; every output 0; cycle counter, idx and err_cnt 0. rst mid-sweep aborts at once.
//   - RUN: cycle counter increments per clk. End marker = dm_we all ones && dm_addr==END_ADDR &&
//     dm_wdata==END_CODE in the same cycle. Partial-byte writes never trigger.
//   - RUN exit: marker -> SWEEP next cycle. Counter reaching MAX_CYCLES-1 -> timeout=1, SWEEP.
//     Marker and expiry in the same cycle: marker wins, timeout stays 0.
//   - SWEEP entry: latch len = min(chk_len, MAX_WORDS). len==0 -> DONE next cycle, no reads.
//   - SWEEP: issue idx = 0..len-1, one per cycle; busy=1. Pipelined: compare slot idx-1 while issuing idx.
//   - Mismatch = chk_rdata != gold_rdata (full-word compare). err_cnt saturates at all ones.
//   - first_err latches only on the first mismatch.
//   - DRAIN: one cycle after the last issue to compare the final slot, then DONE.
//     Total sweep latency = len+1 cycles from SWEEP entry to done=1.
//   - STOP_ON_ERR=1: first mismatch -> DONE next cycle; the one in-flight read is discarded.
//   - DONE: done=1, busy=0, outputs frozen. Snoop ignored; a later END_CODE write has no effect.
//   - Out-of-range addresses wrap modulo 2^AW (TEST_START+idx).
// STRUCTURE
//   - Shared header rv_chk_pkg: state encoding (RUN, SWEEP, DRAIN, DONE), default END_CODE/END_ADDR/
//     TEST_START so bench and RTL agree.
//   - Sub-module chk_sat_counter (parametrised width, saturating): instanced for cycle counter and err_cnt.
//   - Remainder is one FSM + compare pipeline register in this file.
// TESTING
//   - All 16 window words match golden, chk_len=16, marker at cycle 500:
//     done at marker+18 cycles, pass=1, err_cnt=0, timeout=0.
//   - Golden idx 3 and 9 corrupted, STOP_ON_ERR=0:
//     err_cnt=2, first_err=3, pass=0.
//     Same with STOP_ON_ERR=1: done 5 cycles after SWEEP entry, err_cnt=1, first_err=3.
//   - Write 32'hffff_ffff to 'h3fff with dm_we=4'b0111, no full write:
//     no trigger; timeout=1 at cycle MAX_CYCLES, sweep still runs, pass=0 even with 0 errors.
//   - Marker write on the exact expiry cycle: timeout=0, sweep runs, pass per compare.
//   - chk_len=0: done 2 cycles after marker, pass=1, no chk_addr activity.
//     chk_len=5000: clamped to MAX_WORDS.
//   - Assert rst mid-SWEEP (idx=7): outputs all 0 next cycle, state RUN.
//     Re-run completes normally with correct err_cnt.

Source files
------------

// File: rtl/rv_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_chk_pkg
//  Purpose  : Shared definitions for the DM end-of-test result checker.
//             Holds the FSM state encoding and the default end-marker /
//             result-window constants used by both the RTL and the bench.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package rv_chk_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN   = 2'd0;
  localparam state_t ST_SWEEP = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic [13:0] DEF_END_ADDR   = 14'h3fff;
  localparam logic [31:0] DEF_END_CODE   = 32'hffff_ffff;
  localparam logic [13:0] DEF_TEST_START = 14'h2000;

endpackage : rv_chk_pkg
`default_nettype wire

// File: rtl/chk_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : chk_sat_counter
//  Purpose  : Up-counter that sticks at all ones instead of wrapping.
//  Ports    : clk   in  1      clock, rising edge
//             rst   in  1      synchronous active-high reset (count -> 0)
//             inc   in  1      increment request
//             count out WIDTH  current count
//  Revision : 1.0 - initial release
// ============================================================================
module chk_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : chk_sat_counter
`default_nettype wire

// File: rtl/dm_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : dm_result_checker
//  Purpose  : Snoops the DM write port for the end-of-test marker (or a
//             watchdog expiry), then sweeps a DM result window against a
//             golden ROM and reports pass/fail, error count, first bad index.
//  Ports    : clk, rst               clock / sync active-high reset
//             dm_we/dm_addr/dm_wdata snooped DM write port
//             chk_len                golden word count (clamped to MAX_WORDS)
//             chk_addr / chk_rdata   DM read port (1-cycle read latency)
//             gold_addr / gold_rdata golden ROM port (1-cycle read latency)
//             busy, done, pass, timeout, err_cnt, first_err  status
//  Revision : 1.0 - initial release
// ============================================================================
module dm_result_checker
  import rv_chk_pkg::*;
#(
  parameter int            AW          = 14,
  parameter int            DW          = 32,
  parameter logic [AW-1:0] END_ADDR    = DEF_END_ADDR,
  parameter logic [DW-1:0] END_CODE    = DEF_END_CODE,
  parameter logic [AW-1:0] TEST_START  = DEF_TEST_START,
  parameter int            MAX_WORDS   = 1024,
  parameter int            MAX_CYCLES  = 100000,
  parameter bit            STOP_ON_ERR = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DW/8-1:0]                dm_we,
  input  logic [AW-1:0]                  dm_addr,
  input  logic [DW-1:0]                  dm_wdata,
  input  logic [AW:0]                    chk_len,
  output logic [AW-1:0]                  chk_addr,
  input  logic [DW-1:0]                  chk_rdata,
  output logic [AW-1:0]                  gold_addr,
  input  logic [DW-1:0]                  gold_rdata,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic                           timeout,
  output logic [$clog2(MAX_WORDS):0]     err_cnt,
  output logic [$clog2(MAX_WORDS)-1:0]   first_err
);

  localparam int IW  = $clog2(MAX_WORDS);   // slot index width
  localparam int LW  = IW + 1;              // length / error-count width
  localparam int CLW = AW + 1;              // chk_len width
  localparam int CW  = $clog2(MAX_CYCLES);  // watchdog counter width

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic [LW-1:0]   len;
  logic            cmp_valid;    // a read issued last cycle is landing now
  logic [IW-1:0]   cmp_idx;      // slot index of the landing read
  logic            timeout_q;
  logic [IW-1:0]   first_err_q;
  logic [CW-1:0]   cyc;
  logic [LW-1:0]   err_q;

  logic            marker;
  logic            expire;
  logic            issue;
  logic            last_issue;
  logic            mismatch;
  logic [LW-1:0]   len_clamped;

  assign marker = (&dm_we) && (dm_addr == END_ADDR) && (dm_wdata == END_CODE);
  assign expire = (cyc == CW'(MAX_CYCLES - 1));
  assign issue  = (state == ST_SWEEP) && (len != '0);
  assign last_issue = issue && ({1'b0, idx} == (len - LW'(1)));
  // Compares only happen while sweeping; in DONE a landing read is dropped.
  assign mismatch = cmp_valid && (chk_rdata != gold_rdata) &&
                    ((state == ST_SWEEP) || (state == ST_DRAIN));
  assign len_clamped = (chk_len > CLW'(MAX_WORDS)) ? LW'(MAX_WORDS) : LW'(chk_len);

  chk_sat_counter #(.WIDTH(CW)) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (state == ST_RUN),
    .count (cyc)
  );

  chk_sat_counter #(.WIDTH(LW)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mismatch),
    .count (err_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (marker || expire) state_nxt = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (len == '0)                      state_nxt = ST_DONE;
        else if (STOP_ON_ERR && mismatch)   state_nxt = ST_DONE;
        else if (last_issue)                state_nxt = ST_DRAIN;
      end
      ST_DRAIN: state_nxt = ST_DONE;
      default:  state_nxt = ST_DONE;
    endcase
  end

  // Sweep datapath: index, latched length, compare pipeline, sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      len         <= '0;
      cmp_valid   <= 1'b0;
      cmp_idx     <= '0;
      timeout_q   <= 1'b0;
      first_err_q <= '0;
    end else begin
      if (state == ST_RUN) begin
        idx       <= '0;
        cmp_valid <= 1'b0;
        if (marker || expire) len <= len_clamped;
        // The marker wins a tie with the watchdog.
        if (expire && !marker) timeout_q <= 1'b1;
      end else if ((state == ST_SWEEP) || (state == ST_DRAIN)) begin
        cmp_valid <= issue;
        cmp_idx   <= idx;
        if (issue) idx <= idx + IW'(1);
      end
      if (mismatch && (err_q == '0)) first_err_q <= cmp_idx;
    end
  end

  // Outputs
  always_comb begin
    busy      = (state == ST_SWEEP) || (state == ST_DRAIN);
    done      = (state == ST_DONE);
    chk_addr  = issue ? (TEST_START + AW'(idx)) : '0;
    gold_addr = issue ? AW'(idx) : '0;
    timeout   = timeout_q;
    err_cnt   = err_q;
    first_err = first_err_q;
    pass      = (state == ST_DONE) && (err_q == '0) && !timeout_q;
  end

endmodule : dm_result_checker
`default_nettype wire

// File: tb/tb_dm_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_result_checker
//  Purpose  : Directed self-checking bench. Two checker instances share the
//             snoop port and memories: u_dut_a sweeps the whole window,
//             u_dut_b stops at the first mismatch.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dm_result_checker;
  import rv_chk_pkg::*;

  localparam int MAXC = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dm_we;
  logic [13:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [14:0] chk_len;

  logic [13:0] a_chk_addr, a_gold_addr, b_chk_addr, b_gold_addr;
  logic [31:0] a_rd, a_gd, b_rd, b_gd;
  logic        a_busy, a_done, a_pass, a_to;
  logic        b_busy, b_done, b_pass, b_to;
  logic [10:0] a_err, b_err;
  logic [9:0]  a_ferr, b_ferr;

  logic [31:0] dm_mem   [0:16383];
  logic [31:0] gold_mem [0:16383];

  int checks   = 0;
  int failures = 0;
  int na, nb;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_rd <= dm_mem[a_chk_addr];
    a_gd <= gold_mem[a_gold_addr];
    b_rd <= dm_mem[b_chk_addr];
    b_gd <= gold_mem[b_gold_addr];
  end

  dm_result_checker #(.MAX_CYCLES(MAXC), .STOP_ON_ERR(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .chk_len(chk_len), .chk_addr(a_chk_addr), .chk_rdata(a_rd),
    .gold_addr(a_gold_addr), .gold_rdata(a_gd), .busy(a_busy), .done(a_done),
    .pass(a_pass), .timeout(a_to), .err_cnt(a_err), .first_err(a_ferr)
  );

  dm_result_checker #(.MAX_CYCLES(MAXC), .STOP_ON_ERR(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .chk_len(chk_len), .chk_addr(b_chk_addr), .chk_rdata(b_rd),
    .gold_addr(b_gold_addr), .gold_rdata(b_gd), .busy(b_busy), .done(b_done),
    .pass(b_pass), .timeout(b_to), .err_cnt(b_err), .first_err(b_ferr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    dm_we    = '0;
    dm_addr  = '0;
    dm_wdata = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_marker();
    dm_we    = 4'hf;
    dm_addr  = 14'h3fff;
    dm_wdata = 32'hffff_ffff;
    tick();
    dm_we    = '0;
    dm_addr  = '0;
    dm_wdata = '0;
  endtask

  // Ticks until both instances report done; -1 means never seen within bound.
  task automatic wait_done(input int bound, output int ra, output int rb);
    ra = -1;
    rb = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (ra < 0 && a_done) ra = i;
      if (rb < 0 && b_done) rb = i;
      if (ra >= 0 && rb >= 0) break;
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      dm_mem[i]   = 32'h0;
      gold_mem[i] = 32'h0;
    end
    for (int i = 0; i < 2048; i++) begin
      dm_mem[14'h2000 + i] = 32'hc0de_0000 | i;
      gold_mem[i]          = 32'hc0de_0000 | i;
    end
    chk_len = 15'd16;

    // Reset state
    do_reset();
    check("rst_done",  a_done, 0);
    check("rst_busy",  a_busy, 0);
    check("rst_pass",  a_pass, 0);
    check("rst_to",    a_to,   0);
    check("rst_err",   a_err,  0);
    check("rst_ferr",  a_ferr, 0);
    check("rst_caddr", a_chk_addr, 0);

    // All 16 words match, marker at cycle 500
    repeat (500) tick();
    send_marker();
    check("t1_busy",  a_busy, 1);
    check("t1_caddr", a_chk_addr, 14'h2000);
    wait_done(3000, na, nb);
    check("t1_lat_a", na, 17);
    check("t1_lat_b", nb, 17);
    check("t1_pass",  a_pass, 1);
    check("t1_err",   a_err, 0);
    check("t1_to",    a_to, 0);
    check("t1_passb", b_pass, 1);
    // A later marker in DONE is ignored
    send_marker();
    tick();
    check("t1_hold_done", a_done, 1);
    check("t1_hold_busy", a_busy, 0);

    // Golden idx 3 and 9 corrupted
    gold_mem[3] = gold_mem[3] ^ 32'h1;
    gold_mem[9] = gold_mem[9] ^ 32'h8000_0000;
    do_reset();
    repeat (20) tick();
    send_marker();
    wait_done(3000, na, nb);
    check("t2_lat_a",  na, 17);
    check("t2_err_a",  a_err, 2);
    check("t2_ferr_a", a_ferr, 3);
    check("t2_pass_a", a_pass, 0);
    check("t2_lat_b",  nb, 5);
    check("t2_err_b",  b_err, 1);
    check("t2_ferr_b", b_ferr, 3);
    check("t2_pass_b", b_pass, 0);
    gold_mem[3] = 32'hc0de_0003;
    gold_mem[9] = 32'hc0de_0009;

    // Partial-byte marker write never triggers; watchdog does
    do_reset();
    repeat (10) tick();
    dm_we = 4'b0111; dm_addr = 14'h3fff; dm_wdata = 32'hffff_ffff;
    tick();
    dm_we = '0; dm_addr = '0; dm_wdata = '0;
    repeat (MAXC - 1 - 11) tick();
    check("t3_to_pre",   a_to, 0);
    check("t3_busy_pre", a_busy, 0);
    tick();
    check("t3_to",   a_to, 1);
    check("t3_busy", a_busy, 1);
    wait_done(3000, na, nb);
    check("t3_lat",  na, 17);
    check("t3_err",  a_err, 0);
    check("t3_pass", a_pass, 0);

    // Marker on the exact expiry cycle
    do_reset();
    repeat (MAXC - 1) tick();
    send_marker();
    check("t4_to",   a_to, 0);
    check("t4_busy", a_busy, 1);
    wait_done(3000, na, nb);
    check("t4_lat",  na, 17);
    check("t4_pass", a_pass, 1);

    // chk_len = 0
    chk_len = 15'd0;
    do_reset();
    repeat (20) tick();
    send_marker();
    check("t5_caddr", a_chk_addr, 0);
    check("t5_gaddr", a_gold_addr, 0);
    wait_done(3000, na, nb);
    check("t5_lat",  na, 1);
    check("t5_pass", a_pass, 1);

    // chk_len = 5000 clamps to 1024; idx 1024 lies outside the window
    chk_len = 15'd5000;
    gold_mem[1023] = gold_mem[1023] ^ 32'h10;
    gold_mem[1024] = gold_mem[1024] ^ 32'h10;
    do_reset();
    repeat (20) tick();
    send_marker();
    wait_done(3000, na, nb);
    check("t6_lat_a",  na, 1025);
    check("t6_err_a",  a_err, 1);
    check("t6_ferr_a", a_ferr, 1023);
    check("t6_lat_b",  nb, 1025);
    check("t6_err_b",  b_err, 1);
    gold_mem[1023] = 32'hc0de_03ff;
    gold_mem[1024] = 32'hc0de_0400;

    // Reset mid-sweep at idx 7, then re-run
    chk_len = 15'd16;
    gold_mem[3] = gold_mem[3] ^ 32'h1;
    gold_mem[9] = gold_mem[9] ^ 32'h1;
    do_reset();
    repeat (30) tick();
    send_marker();
    repeat (7) tick();
    check("t7_caddr_mid", a_chk_addr, 14'h2007);
    check("t7_err_mid",   a_err, 1);
    rst = 1'b1;
    tick();
    check("t7_rst_busy",  a_busy, 0);
    check("t7_rst_err",   a_err, 0);
    check("t7_rst_ferr",  a_ferr, 0);
    check("t7_rst_caddr", a_chk_addr, 0);
    check("t7_rst_doneb", b_done, 0);
    rst = 1'b0;
    repeat (50) tick();
    send_marker();
    wait_done(3000, na, nb);
    check("t7_lat",  na, 17);
    check("t7_err",  a_err, 2);
    check("t7_ferr", a_ferr, 3);
    check("t7_pass", a_pass, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dm_result_checker
`default_nettype wire
